// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp controller: walks the PWM duty toward a requested target on period boundaries.
// Optional soft-stop ramp-down on en deassertion is compiled in with PWM_RAMP_SOFTSTOP_EN.
module pwm_duty_ramp #(
    parameter int DW    = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cycle_in,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [DW-1:0]    tgt_duty,
    input  logic [DW-1:0]    step,
    input  logic [DIV_W-1:0] periods_per_step,
    output logic [DW-1:0]    duty_out,
    output logic             busy,
    output logic             done
);

`ifdef PWM_RAMP_SOFTSTOP_EN
    typedef enum logic [1:0] {IDLE, RAMP, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RAMP} state_t;
`endif

    state_t           state_q, state_d;
    logic [DW-1:0]    duty_q, duty_d;
    logic [DW-1:0]    tgt_q, tgt_d;
    logic [DW-1:0]    step_q, step_d;
    logic [DIV_W-1:0] pps_q, pps_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic [DW-1:0]    step_eff;
    logic [DIV_W-1:0] pps_eff;
    logic [DW:0]      diff_up, diff_dn;
    logic [DW-1:0]    ramp_duty;
    logic             accept;

    assign step_eff = (step == '0) ? DW'(1) : step;
    assign pps_eff  = (periods_per_step == '0) ? DIV_W'(1) : periods_per_step;
    assign accept   = tgt_valid && ready_q;

    // Differences carry an extra bit so the clamp never wraps at either end of the range.
    assign diff_up = {1'b0, tgt_q} - {1'b0, duty_q};
    assign diff_dn = {1'b0, duty_q} - {1'b0, tgt_q};

    always_comb begin
        ramp_duty = duty_q;
        if (tgt_q >= duty_q) begin
            ramp_duty = (diff_up <= {1'b0, step_q}) ? tgt_q : duty_q + step_q;
        end else begin
            ramp_duty = (diff_dn <= {1'b0, step_q}) ? tgt_q : duty_q - step_q;
        end
    end

`ifdef PWM_RAMP_SOFTSTOP_EN
    logic [DW-1:0] stop_duty;
    assign stop_duty = ({1'b0, duty_q} <= {1'b0, step_q}) ? '0 : duty_q - step_q;
`endif

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        pps_d   = pps_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!en) begin
`ifdef PWM_RAMP_SOFTSTOP_EN
                    if (duty_q != '0) begin
                        state_d = STOP;
                        cnt_d   = pps_q;
                    end
`else
                    duty_d = '0;
`endif
                end else if (accept) begin
                    tgt_d  = tgt_duty;
                    step_d = step_eff;
                    pps_d  = pps_eff;
                    cnt_d  = pps_eff;
                    if (tgt_duty == duty_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end

            RAMP: begin
                if (!en) begin
`ifdef PWM_RAMP_SOFTSTOP_EN
                    state_d = STOP;
                    cnt_d   = pps_q;
`else
                    state_d = IDLE;
                    duty_d  = '0;
`endif
                end else if (cycle_in) begin
                    if (cnt_q <= DIV_W'(1)) begin
                        duty_d = ramp_duty;
                        cnt_d  = pps_q;
                        if (ramp_duty == tgt_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - DIV_W'(1);
                    end
                end
            end

`ifdef PWM_RAMP_SOFTSTOP_EN
            // Soft stop runs to completion regardless of en and never signals done.
            STOP: begin
                if (duty_q == '0) begin
                    state_d = IDLE;
                end else if (cycle_in) begin
                    if (cnt_q <= DIV_W'(1)) begin
                        duty_d = stop_duty;
                        cnt_d  = pps_q;
                        if (stop_duty == '0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - DIV_W'(1);
                    end
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) && en;
    end

    // Latched step/period default to 1 so a soft stop before any accept still makes progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= DW'(1);
            pps_q   <= DIV_W'(1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            pps_q   <= pps_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign duty_out  = duty_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tgt_ready = ready_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed self-checking bench for pwm_duty_ramp; follows PWM_RAMP_SOFTSTOP_EN like the design.
module tb_pwm_duty_ramp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cycle_in;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [7:0] tgt_duty;
    logic [7:0] step;
    logic [7:0] periods_per_step;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    pwm_duty_ramp #(.DW(8), .DIV_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .cycle_in         (cycle_in),
        .tgt_valid        (tgt_valid),
        .tgt_ready        (tgt_ready),
        .tgt_duty         (tgt_duty),
        .step             (step),
        .periods_per_step (periods_per_step),
        .duty_out         (duty_out),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One idle clock, then a single-clock period boundary pulse.
    task automatic pulse_cycle();
        tick();
        cycle_in = 1'b1;
        tick();
        cycle_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; cycle_in = 1'b0; tgt_valid = 1'b0;
        tgt_duty = '0; step = '0; periods_per_step = '0;
        repeat (3) tick();
        checks++; if (duty_out !== 8'd0) begin errors++; $display("[TB] FAIL reset_duty got %0d exp 0", duty_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done); end
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b exp 0", tgt_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_release got %b exp 1", tgt_ready); end
        checks++; if (duty_out !== 8'd0) begin errors++; $display("[TB] FAIL duty_after_release got %0d exp 0", duty_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_release got %b exp 0", busy); end
    endtask

    task automatic test_ramp_up();
        logic [7:0] exp_tab [8];
        logic       exp_done;
        exp_tab = '{8'd0, 8'd64, 8'd64, 8'd128, 8'd128, 8'd192, 8'd192, 8'd200};
        tgt_valid = 1'b1; tgt_duty = 8'd200; step = 8'd64; periods_per_step = 8'd2;
        tick();
        tgt_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL up_busy_after_accept got %b exp 1", busy); end
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("[TB] FAIL up_ready_after_accept got %b exp 0", tgt_ready); end
        for (int k = 0; k < 8; k++) begin
            pulse_cycle();
            exp_done = (k == 7);
            checks++; if (duty_out !== exp_tab[k]) begin errors++; $display("[TB] FAIL up_duty boundary %0d got %0d exp %0d", k + 1, duty_out, exp_tab[k]); end
            checks++; if (done !== exp_done) begin errors++; $display("[TB] FAIL up_done boundary %0d got %b exp %b", k + 1, done, exp_done); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL up_busy_at_done got %b exp 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL up_done_single_pulse got %b exp 0", done); end
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("[TB] FAIL up_ready_after_done got %b exp 1", tgt_ready); end
        checks++; if (duty_out !== 8'd200) begin errors++; $display("[TB] FAIL up_duty_held got %0d exp 200", duty_out); end
    endtask

    task automatic test_ramp_down();
        logic [7:0] exp_duty;
        logic       exp_done;
        tgt_valid = 1'b1; tgt_duty = 8'd5; step = 8'd0; periods_per_step = 8'd0;
        tick();
        tgt_valid = 1'b0;
        for (int k = 1; k <= 195; k++) begin
            pulse_cycle();
            exp_duty = 8'(200 - k);
            exp_done = (k == 195);
            checks++; if (duty_out !== exp_duty) begin errors++; $display("[TB] FAIL down_duty update %0d got %0d exp %0d", k, duty_out, exp_duty); end
            checks++; if (done !== exp_done) begin errors++; $display("[TB] FAIL down_done update %0d got %b exp %b", k, done, exp_done); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL down_busy_at_done got %b exp 0", busy); end
        pulse_cycle();
        checks++; if (duty_out !== 8'd5) begin errors++; $display("[TB] FAIL down_no_wrap got %0d exp 5", duty_out); end
    endtask

    task automatic test_equal_target();
        tgt_valid = 1'b1; tgt_duty = 8'd5; step = 8'd3; periods_per_step = 8'd4;
        tick();
        tgt_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL eq_done got %b exp 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL eq_busy got %b exp 0", busy); end
        checks++; if (duty_out !== 8'd5) begin errors++; $display("[TB] FAIL eq_duty got %0d exp 5", duty_out); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL eq_done_clear got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL eq_busy_later got %b exp 0", busy); end
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("[TB] FAIL eq_ready got %b exp 1", tgt_ready); end
    endtask

    task automatic test_back_to_back();
        tgt_valid = 1'b1; tgt_duty = 8'd100; step = 8'd50; periods_per_step = 8'd1;
        tick();
        // Hold a new request while the first ramp runs; its data differs to expose early sampling.
        tgt_duty = 8'd50; periods_per_step = 8'd2;
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_mid got %b exp 0", tgt_ready); end
        pulse_cycle();
        checks++; if (duty_out !== 8'd55) begin errors++; $display("[TB] FAIL b2b_first_step got %0d exp 55", duty_out); end
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_stall got %b exp 0", tgt_ready); end
        pulse_cycle();
        checks++; if (duty_out !== 8'd100) begin errors++; $display("[TB] FAIL b2b_final got %0d exp 100", duty_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done got %b exp 1", done); end
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after_done got %b exp 1", tgt_ready); end
        cycle_in = 1'b1;
        tick();
        cycle_in = 1'b0; tgt_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_accept_busy got %b exp 1", busy); end
        checks++; if (duty_out !== 8'd100) begin errors++; $display("[TB] FAIL b2b_accept_clock_cycle got %0d exp 100", duty_out); end
        pulse_cycle();
        checks++; if (duty_out !== 8'd100) begin errors++; $display("[TB] FAIL b2b_first_boundary got %0d exp 100", duty_out); end
        pulse_cycle();
        checks++; if (duty_out !== 8'd50) begin errors++; $display("[TB] FAIL b2b_second_boundary got %0d exp 50", duty_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_done got %b exp 1", done); end
    endtask

    task automatic test_stop();
        tgt_valid = 1'b1; tgt_duty = 8'd150; step = 8'd20; periods_per_step = 8'd1;
        tick();
        tgt_valid = 1'b0;
        pulse_cycle();
        pulse_cycle();
        checks++; if (duty_out !== 8'd90) begin errors++; $display("[TB] FAIL stop_pre got %0d exp 90", duty_out); end
        en = 1'b0;
        tick();
`ifdef PWM_RAMP_SOFTSTOP_EN
        begin
            logic [7:0] exp_tab [5];
            logic       exp_busy;
            exp_tab = '{8'd70, 8'd50, 8'd30, 8'd10, 8'd0};
            checks++; if (duty_out !== 8'd90) begin errors++; $display("[TB] FAIL stop_hold got %0d exp 90", duty_out); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stop_busy got %b exp 1", busy); end
            for (int k = 0; k < 5; k++) begin
                pulse_cycle();
                if (k == 0) en = 1'b1;
                exp_busy = (k != 4);
                checks++; if (duty_out !== exp_tab[k]) begin errors++; $display("[TB] FAIL stop_duty boundary %0d got %0d exp %0d", k + 1, duty_out, exp_tab[k]); end
                checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL stop_done boundary %0d got %b exp 0", k + 1, done); end
                checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL stop_busy boundary %0d got %b exp %b", k + 1, busy, exp_busy); end
                checks++; if (tgt_ready !== !exp_busy) begin errors++; $display("[TB] FAIL stop_ready boundary %0d got %b exp %b", k + 1, tgt_ready, !exp_busy); end
            end
        end
`else
        checks++; if (duty_out !== 8'd0) begin errors++; $display("[TB] FAIL stop_duty_zero got %0d exp 0", duty_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL stop_done got %b exp 0", done); end
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("[TB] FAIL stop_ready got %b exp 0", tgt_ready); end
        pulse_cycle();
        checks++; if (duty_out !== 8'd0) begin errors++; $display("[TB] FAIL stop_discard got %0d exp 0", duty_out); end
        en = 1'b1;
        tick();
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("[TB] FAIL stop_ready_reen got %b exp 1", tgt_ready); end
`endif
    endtask

    task automatic test_reset_midramp();
        tgt_valid = 1'b1; tgt_duty = 8'd100; step = 8'd10; periods_per_step = 8'd1;
        tick();
        tgt_valid = 1'b0;
        pulse_cycle();
        pulse_cycle();
        checks++; if (duty_out !== 8'd20) begin errors++; $display("[TB] FAIL rst_pre got %0d exp 20", duty_out); end
        rst_n = 1'b0;
        #2;
        checks++; if (duty_out !== 8'd0) begin errors++; $display("[TB] FAIL rst_async_duty got %0d exp 0", duty_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_busy got %b exp 0", busy); end
        checks++; if (tgt_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_ready got %b exp 0", tgt_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (tgt_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready_again got %b exp 1", tgt_ready); end
        pulse_cycle();
        checks++; if (duty_out !== 8'd0) begin errors++; $display("[TB] FAIL rst_no_partial got %0d exp 0", duty_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy_after got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_equal_target();
        test_back_to_back();
        test_stop();
        test_reset_midramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Duty-cycle ramp controller for the 8-bit PWM generator.
- Accepts a target duty through a valid/ready handshake.
- Drives the PWM `duty` input toward the target in bounded steps.
- Updates duty only on PWM period boundaries, signalled by the generator's one-clock `cycle` pulse, so no period is ever truncated.
- Sits between the host/config logic and the PWM datapath. Gives soft-start and glitch-free duty changes.

## Interface
- `DW`, 8, duty width; must match the PWM `duty` input.
- `DIV_W`, 8, width of the periods-per-step divider.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  ramp enable; low = stop output (see Operation).
- `cycle_in`  in  1  one-clock pulse at each PWM period boundary.
- `tgt_valid`  in  1  target request valid.
- `tgt_ready`  out  1  controller can accept a target.
- `tgt_duty`  in  DW  requested final duty.
- `step`  in  DW  duty increment per update; 0 treated as 1.
- `periods_per_step`  in  DIV_W  PWM periods between updates; 0 treated as 1.
- `duty_out`  out  DW  registered duty to the PWM.
- `busy`  out  1  ramp in progress.
- `done`  out  1  one-clock pulse when `duty_out` reaches the accepted target.

## Operation
- States: IDLE, RAMP, STOP. STOP exists only with the macro enabled.
- **Accept:** `tgt_valid && tgt_ready`. The controller latches `tgt_duty`, `step` and `periods_per_step` (after 0→1 substitution) and loads the period counter with `periods_per_step`.
  - Accept with target == `duty_out`: stay IDLE, pulse `done` next clock.
  - Otherwise: go to RAMP, `busy`=1.
- **RAMP:**
  - Each `cycle_in` decrements the period counter.
  - When the counter is 1 at a `cycle_in`, the controller updates duty and reloads the counter.
  - Update rule: move toward the target by the latched step, clamped to the target.
  - Difference is computed in DW+1 bits, so there is no overshoot and no wrap at 0 or 2^DW−1.
  - When the updated duty equals the target: go to IDLE, `busy`=0, `done`=1 on the same clock that `duty_out` takes the final value.
- **Handshake:** `tgt_ready` is registered and equals next-state==IDLE && `en`. New targets are not accepted mid-ramp; `tgt_valid` may be held. Input data is sampled only at accept.
- **`cycle_in` on the accept clock** is ignored. Counting starts at the next boundary.
- **`en` low, macro absent:** `duty_out`←0, state←IDLE, `busy`←0 on the next clock, no `done`. An in-flight ramp is discarded.
- **`en` low with an in-flight ramp, macro present:** see Configuration.
- **Reset mid-ramp:** immediate return to reset values. No partial update survives.

## Timing
- Reset values: `duty_out`=0, `busy`=0, `done`=0, `tgt_ready`=0, state IDLE, counter 0.
- `tgt_ready` rises on the first clock after `rst_n` deasserts if `en`=1.
- `duty_out` changes exactly one clock after the qualifying `cycle_in`. It is held constant across the whole PWM period.
- Ramp length = ceil(|target−start|/step) updates × `periods_per_step` periods.
- `busy` rises the clock after accept. It falls on the same clock as `done`.
- `tgt_ready` falls the clock after accept. It rises again the clock after `done`.

## Configuration
- Macro: `PWM_RAMP_SOFTSTOP_EN`.
- **Defined:** deasserting `en` enters STOP from IDLE or RAMP.
  - STOP ramps `duty_out` down to 0 using the last latched step and `periods_per_step`, at period boundaries.
  - If no target has been accepted since reset, STOP uses step 1 and 1 period.
  - `busy`=1 and `tgt_ready`=0 throughout STOP.
  - On reaching 0: go to IDLE, no `done`.
  - Reasserting `en` during STOP does not abort it. Accepts resume after IDLE.
  - STOP with `duty_out` already 0 returns to IDLE next clock.
- **Undefined:** STOP state and logic are not compiled. `en` low forces `duty_out` to 0 on the next clock, as in Operation.

## Test plan
- **Reset/accept:** reset; release with `en`=1 → `tgt_ready`=1 one clock later. `duty_out`=0, `busy`=0.
- **Ramp up:** target 200, step 64, periods_per_step 2 → `duty_out` 64, 128, 192, 200 on every 2nd `cycle_in`. `done` pulses with 200. 8 boundaries total.
- **Ramp down with clamp/zero step:** from 200, target 5, step 0 (→1), periods_per_step 0 (→1) → decrements by 1 per boundary. Exactly 195 updates, final 5, no wrap.
- **Equal target:** target 5 while `duty_out`=5 → stays IDLE, `done` one clock after accept, `busy` never high.
- **Handshake stall:** hold `tgt_valid` with 50 during a ramp to 100 → not accepted until the clock after `done`. Then the ramp to 50 starts. `cycle_in` on the accept clock does not count.
- **Stop/reset:** `en` low mid-ramp → macro off: `duty_out`=0 next clock. Macro on: steps down to 0 at boundaries, no `done`. `rst_n` low mid-ramp → all outputs 0 asynchronously.
